// File: rtl/guess_round_ctrl_if.sv
// Gameplay bus between the difficulty/input side and the round controller.
interface guess_round_ctrl_if;
  logic       confirmButton;
  logic [9:0] guess;
  logic [1:0] max_digit;
  logic       tick_1hz;
  logic [2:0] round;
  logic [2:0] incorrect_guesses;
  logic [6:0] timer;
  logic [1:0] hint;
  logic       busy;

  // Stimulus side: drives the player inputs and observes the game state.
  modport master (
    output confirmButton, guess, max_digit, tick_1hz,
    input  round, incorrect_guesses, timer, hint, busy
  );

  // Controller side.
  modport slave (
    input  confirmButton, guess, max_digit, tick_1hz,
    output round, incorrect_guesses, timer, hint, busy
  );
endinterface

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the number-guessing game: LFSR target generation,
// guess checking, per-level round/miss counters and countdown timer.
module guess_round_ctrl #(
  parameter int unsigned TIME_STEP = 30,
  parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
  input logic               clk,
  input logic               restart,
  guess_round_ctrl_if.slave bus
);

  localparam int unsigned VAL_W   = 10;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TIMER_W = 7;

  typedef enum logic [2:0] {IDLE, GEN, PLAY, CHECK, DONE} state_t;

  state_t               state_q, state_d;
  logic [VAL_W-1:0]     lfsr_q;
  logic [VAL_W-1:0]     target_q, target_d;
  logic [VAL_W-1:0]     guess_q, guess_d;
  logic [1:0]           max_digit_q;
  logic                 confirm_q;
  logic [CNT_W-1:0]     round_q, round_d;
  logic [CNT_W-1:0]     inc_q, inc_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [1:0]           hint_q, hint_d;
  logic                 busy_q;

  logic [VAL_W-1:0]     candidate_c;
  logic [VAL_W-1:0]     limit_c;
  logic                 confirm_edge_c;
  logic                 level_entry_c;
  logic [TIMER_W-1:0]   timer_load_c;
  logic [TIMER_W-1:0]   timer_tick_c;

  // Shared decode: candidate target, level limit, input edges, timer arithmetic.
  always_comb begin
    candidate_c    = lfsr_q - VAL_W'(1);
    confirm_edge_c = bus.confirmButton & ~confirm_q;
    level_entry_c  = (bus.max_digit != max_digit_q) && (bus.max_digit != 2'd0);
    timer_load_c   = TIMER_W'(TIME_STEP * 32'(bus.max_digit));
    timer_tick_c   = (bus.tick_1hz && (timer_q != '0)) ? timer_q - TIMER_W'(1) : timer_q;
    unique case (bus.max_digit)
      2'd1:    limit_c = VAL_W'(10);
      2'd2:    limit_c = VAL_W'(100);
      2'd3:    limit_c = VAL_W'(1000);
      default: limit_c = '0;
    endcase
  end

  // Next-state and datapath updates; level entry outranks everything, then game end.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    guess_d  = guess_q;
    round_d  = round_q;
    inc_d    = inc_q;
    timer_d  = timer_q;
    hint_d   = hint_q;
    if (level_entry_c) begin
      state_d = GEN;
      round_d = '0;
      inc_d   = '0;
      timer_d = timer_load_c;
      hint_d  = 2'b00;
    end else if (bus.max_digit == 2'd0) begin
      state_d = DONE;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        GEN: begin
          if (candidate_c < limit_c) begin
            target_d = candidate_c;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          timer_d = timer_tick_c;
          // Acceptance looks at the registered timer, so a guess on the last tick still counts.
          if (confirm_edge_c && (timer_q != '0)) begin
            guess_d = bus.guess;
            state_d = CHECK;
          end
        end
        CHECK: begin
          timer_d = timer_tick_c;
          if (guess_q == target_q) begin
            hint_d  = 2'b11;
            round_d = (round_q == '1) ? round_q : round_q + CNT_W'(1);
            state_d = GEN;
          end else begin
            hint_d  = (guess_q < target_q) ? 2'b01 : 2'b10;
            inc_d   = (inc_q == '1) ? inc_q : inc_q + CNT_W'(1);
            state_d = PLAY;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, LFSR and output registers with synchronous restart.
  always_ff @(posedge clk) begin
    if (restart) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      target_q    <= '0;
      guess_q     <= '0;
      max_digit_q <= 2'd0;
      confirm_q   <= 1'b0;
      round_q     <= '0;
      inc_q       <= '0;
      timer_q     <= '0;
      hint_q      <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      target_q    <= target_d;
      guess_q     <= guess_d;
      max_digit_q <= bus.max_digit;
      confirm_q   <= bus.confirmButton;
      round_q     <= round_d;
      inc_q       <= inc_d;
      timer_q     <= timer_d;
      hint_q      <= hint_d;
      busy_q      <= (state_d == GEN);
    end
  end

  assign bus.round             = round_q;
  assign bus.incorrect_guesses = inc_q;
  assign bus.timer             = timer_q;
  assign bus.hint              = hint_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Scoreboard bench for guess_round_ctrl: a game-level model predicts the
// outputs and the cycle they appear; a negedge monitor compares them.
module tb_guess_round_ctrl;

  localparam int TS   = 30;
  localparam int SEED = 'h2A5;

  logic clk = 1'b0;
  logic restart;
  guess_round_ctrl_if bus ();

  guess_round_ctrl #(.TIME_STEP(TS), .LFSR_SEED(10'h2A5)) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      name;
    logic [1:0] hint;
    logic [2:0] round;
    logic [2:0] inc;
    logic [6:0] timer;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   lfsr_m = SEED;

  // Game-level reference state.
  int m_round, m_inc, m_timer, m_hint, m_target, m_limit;

  function automatic int step(input int v);
    int fb;
    fb = ((v >> 9) ^ (v >> 6)) & 1;
    return ((v << 1) | fb) & 'h3FF;
  endfunction

  // Free-running reference LFSR (runs in every state, reseeded by restart).
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    lfsr_m <= restart ? SEED : step(lfsr_m);
  end

  function automatic void push(input string nm, input int due, input logic b);
    exp_t e;
    e.due   = due;
    e.name  = nm;
    e.hint  = 2'(m_hint);
    e.round = 3'(m_round);
    e.inc   = 3'(m_inc);
    e.timer = 7'(m_timer);
    e.busy  = b;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation scheduled for this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checks++;
        if (bus.hint !== sb[i].hint || bus.round !== sb[i].round ||
            bus.incorrect_guesses !== sb[i].inc || bus.timer !== sb[i].timer ||
            bus.busy !== sb[i].busy) begin
          errors++;
          $display("FAIL %s cyc=%0d got hint=%0d round=%0d inc=%0d timer=%0d busy=%0d exp hint=%0d round=%0d inc=%0d timer=%0d busy=%0d",
                   sb[i].name, cyc, bus.hint, bus.round, bus.incorrect_guesses, bus.timer, bus.busy,
                   sb[i].hint, sb[i].round, sb[i].inc, sb[i].timer, sb[i].busy);
        end
        sb.delete(i);
      end
    end
  end

  function automatic int wrong_guess();
    if (m_target > 0 && (($urandom % 2) == 0 || m_target >= 999))
      return int'($urandom_range(m_target - 1, 0));
    return int'($urandom_range(999, m_target + 1));
  endfunction

  // Called at a negedge when the next edge enters target generation.
  task automatic expect_gen(input string nm);
    int v, k, entry;
    v = step(lfsr_m);
    k = 0;
    while (v - 1 >= m_limit) begin
      v = step(v);
      k++;
    end
    m_target = v - 1;
    entry    = cyc + 1;
    push({nm, "_gen"}, entry, 1'b1);
    push({nm, "_play"}, entry + k + 1, 1'b0);
    repeat (k + 2) @(negedge clk);
  endtask

  task automatic level_model(input int d);
    m_round = 0;
    m_inc   = 0;
    m_hint  = 0;
    m_timer = (TS * d) & 127;
    m_limit = (d == 1) ? 10 : (d == 2) ? 100 : 1000;
  endtask

  task automatic enter_level(input int d, input string nm);
    bus.max_digit = 2'(d);
    level_model(d);
    expect_gen(nm);
  endtask

  task automatic do_confirm(input int g, input bit tk, input bit hold, input string nm);
    bit acc, correct;
    bus.confirmButton = 1'b1;
    bus.guess         = 10'(g);
    bus.tick_1hz      = tk;
    acc     = (m_timer > 0);
    correct = 1'b0;
    if (tk && m_timer > 0) m_timer--;
    if (acc) begin
      if (g == m_target) begin
        m_hint  = 3;
        m_round = (m_round < 7) ? m_round + 1 : 7;
        correct = 1'b1;
      end else begin
        m_hint = (g < m_target) ? 1 : 2;
        m_inc  = (m_inc < 7) ? m_inc + 1 : 7;
      end
    end
    @(negedge clk);
    if (!hold) bus.confirmButton = 1'b0;
    bus.tick_1hz = 1'b0;
    if (correct) expect_gen(nm);
    else begin
      push(nm, cyc + 1, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic ticks(input int n, input string nm);
    repeat (n) begin
      bus.tick_1hz = 1'b1;
      if (m_timer > 0) m_timer--;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
      @(negedge clk);
    end
    push(nm, cyc + 1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d expired before end of test", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    restart           = 1'b1;
    bus.confirmButton = 1'b0;
    bus.guess         = '0;
    bus.max_digit     = 2'd0;
    bus.tick_1hz      = 1'b0;
    m_round = 0; m_inc = 0; m_timer = 0; m_hint = 0; m_target = 0; m_limit = 0;

    repeat (3) @(negedge clk);
    push("reset", cyc + 1, 1'b0);
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);

    // Level 1: below, above-limit, random above, hit.
    enter_level(1, "lvl1");
    if (m_target > 0) do_confirm(int'($urandom_range(m_target - 1, 0)), 1'b0, 1'b0, "low1");
    do_confirm(999, 1'b0, 1'b0, "over_limit");
    do_confirm(int'($urandom_range(999, m_target + 1)), 1'b0, 1'b0, "high1");
    do_confirm(m_target, 1'b0, 1'b0, "hit1");

    // Held button counts as a single guess.
    do_confirm(wrong_guess(), 1'b0, 1'b1, "hold");
    repeat (48) @(negedge clk);
    push("hold_end", cyc + 1, 1'b0);
    @(negedge clk);
    bus.confirmButton = 1'b0;
    @(negedge clk);

    while (m_round < 4) begin
      do_confirm(wrong_guess(), 1'b0, 1'b0, "miss");
      do_confirm(m_target, 1'b0, 1'b0, "hit");
    end
    repeat (9) do_confirm(wrong_guess(), 1'b0, 1'b0, "sat_inc");

    // Timer run-down, last-second guess, hold at zero, ignored confirm.
    ticks(m_timer - 1, "timer_one");
    do_confirm(m_target, 1'b1, 1'b0, "tick_coincide");
    ticks(3, "timer_hold0");
    do_confirm(m_target, 1'b0, 1'b0, "confirm_at_zero");

    // Level 2: fresh counters and timer, round saturation.
    enter_level(2, "lvl2");
    do_confirm(wrong_guess(), 1'b0, 1'b0, "miss2");
    repeat (8) do_confirm(m_target, 1'b0, 1'b0, "hit2");

    // Game end freezes everything regardless of inputs.
    bus.max_digit = 2'd0;
    push("done", cyc + 1, 1'b0);
    repeat (10) begin
      bus.tick_1hz      = 1'b1;
      bus.confirmButton = 1'b1;
      bus.guess         = 10'($urandom_range(999, 0));
      @(negedge clk);
      bus.tick_1hz      = 1'b0;
      bus.confirmButton = 1'b0;
      @(negedge clk);
    end
    push("done_frozen", cyc + 1, 1'b0);
    @(negedge clk);

    // Level 3 from DONE, then restart while a guess is in CHECK.
    enter_level(3, "lvl3");
    do_confirm(wrong_guess(), 1'b0, 1'b0, "miss3");
    bus.confirmButton = 1'b1;
    bus.guess         = 10'(wrong_guess());
    @(negedge clk);
    bus.confirmButton = 1'b0;
    restart = 1'b1;
    m_round = 0; m_inc = 0; m_timer = 0; m_hint = 0;
    push("restart_in_check", cyc + 1, 1'b0);
    @(negedge clk);
    restart = 1'b0;
    level_model(3);
    expect_gen("relaunch");
    do_confirm(m_target, 1'b0, 1'b0, "hit3");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d pending entries, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
